// File: rtl/store_mem_req.sv
// store_mem_req: store-side memory request formatter.
// Takes a decoded SB/SH/SW from execute, replicates the data across the byte
// lanes, builds byte selects and a word address, then runs the write
// handshake to data memory. The pipeline is stalled until the write is
// acknowledged, rejected as misaligned, or abandoned on timeout.
module store_mem_req #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 1..65535 WAIT cycles before bus_err
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        mem_busy,
  input  logic        mem_ack,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        stall,
  output logic        st_done,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0]  OP_SB = 2'b00;
  localparam logic [1:0]  OP_SH = 2'b01;
  localparam logic [1:0]  OP_SW = 2'b10;
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] waitCount;
  logic [31:0] fmtData;
  logic [3:0]  fmtSel;
  logic        isMisaligned;

  // Lane formatting and alignment check for the request presented in IDLE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    fmtData      = st_data;
    fmtSel       = 4'b1111;
    isMisaligned = 1'b0;
    case (st_op)
      OP_SB: begin
        fmtData = {4{st_data[7:0]}};
        fmtSel  = 4'b0001 << st_addr[1:0];
      end
      OP_SH: begin
        fmtData      = {2{st_data[15:0]}};
        fmtSel       = st_addr[1] ? 4'b1100 : 4'b0011;
        isMisaligned = st_addr[0];
      end
      OP_SW: begin
        fmtData      = st_data;
        fmtSel       = 4'b1111;
        isMisaligned = (st_addr[1:0] != 2'b00);
      end
      default: begin
        isMisaligned = 1'b1;
      end
    endcase
  end

  // Hold the pipeline while a request is pending, including the IDLE cycle
  // in which it is first presented.
  assign stall = st_valid & ((state == IDLE) | (state == REQ) | (state == WAIT));

  // Handshake FSM; all memory-side outputs and status flags are registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      waitCount <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st_valid) begin
            if (isMisaligned) begin
              misalign <= 1'b1;
              state    <= ERR;
            end else begin
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= fmtData;
              mem_sel   <= fmtSel;
              mem_wen   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // While busy the request and its payload are simply held.
          if (!mem_busy) begin
            mem_wen <= 1'b0;
            if (mem_ack) begin
              st_done <= 1'b1;
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            waitCount <= '0;
            st_done   <= 1'b1;
            state     <= DONE;
          end else if (waitCount == LAST_COUNT) begin
            waitCount <= '0;
            bus_err   <= 1'b1;
            state     <= ERR;
          end else begin
            waitCount <= waitCount + 16'd1;
          end
        end
        DONE: begin
          // Wait for the CPU to drop st_valid so one request means one write.
          if (!st_valid) begin
            st_done <= 1'b0;
            state   <= IDLE;
          end
        end
        ERR: begin
          if (!st_valid) begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
